// File: rtl/distortion_frame_ctrl.sv
// distortion_frame_ctrl
// Frame and line-window sequencer for the barrel distortion correction path.
// Tracks accepted input/output AXI4-Stream beats, opens the upstream tready
// window only while a line-buffer slot is free, lets the remap engine issue an
// output line only once enough source lines are buffered, checks SOF/EOL
// framing and swaps in the distortion coefficient at frame boundaries.

module distortion_frame_ctrl #(
    parameter int WIDTH        = 1920,
    parameter int HEIGHT       = 1080,
    parameter int BUFFER_LINES = 4,
    parameter int LOOKAHEAD    = 2,
    parameter int COORD_WIDTH  = 16,
    parameter int K_WIDTH      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [K_WIDTH-1:0]     cfg_k1,
    input  logic                   cfg_enable,
    input  logic                   cfg_update,
    output logic [K_WIDTH-1:0]     active_k1,
    output logic                   active_bypass,
    input  logic                   in_beat,
    input  logic                   in_last,
    input  logic                   in_user,
    output logic                   in_allow,
    input  logic                   out_beat,
    output logic                   out_allow,
    output logic                   out_abort,
    output logic [COORD_WIDTH-1:0] in_line,
    output logic [COORD_WIDTH-1:0] out_line,
    output logic                   frame_done,
    output logic                   err_sof,
    output logic                   err_eol,
    input  logic                   err_clear,
    output logic [1:0]             state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_RESYNC = 2'd3
    } state_t;

    // Geometry constants in counter width; the window math uses one extra
    // bit so out_line+LOOKAHEAD cannot wrap.
    localparam logic [COORD_WIDTH-1:0] LP_X_LAST    = COORD_WIDTH'(WIDTH - 1);
    localparam logic [COORD_WIDTH-1:0] LP_HEIGHT    = COORD_WIDTH'(HEIGHT);
    localparam logic [COORD_WIDTH:0]   LP_HEIGHT_M1 = (COORD_WIDTH + 1)'(HEIGHT - 1);
    localparam logic [COORD_WIDTH:0]   LP_LOOK      = (COORD_WIDTH + 1)'(LOOKAHEAD);
    localparam logic [COORD_WIDTH:0]   LP_BUF       = (COORD_WIDTH + 1)'(BUFFER_LINES);

    // Registered state
    state_t                   r_state;
    logic [COORD_WIDTH-1:0]   r_in_x;
    logic [COORD_WIDTH-1:0]   r_in_line;
    logic [COORD_WIDTH-1:0]   r_out_x;
    logic [COORD_WIDTH-1:0]   r_out_line;
    logic                     r_in_allow;
    logic                     r_out_allow;
    logic                     r_out_abort;
    logic                     r_frame_done;
    logic                     r_err_sof;
    logic                     r_err_eol;
    logic [K_WIDTH-1:0]       r_pend_k1;
    logic                     r_pend_en;
    logic                     r_pend_vld;
    logic [K_WIDTH-1:0]       r_active_k1;
    logic                     r_active_bypass;

    // Next-state / combinational wires
    state_t                   w_state_nx;
    logic [COORD_WIDTH-1:0]   w_in_x_nx;
    logic [COORD_WIDTH-1:0]   w_in_line_nx;
    logic [COORD_WIDTH-1:0]   w_out_x_nx;
    logic [COORD_WIDTH-1:0]   w_out_line_nx;
    logic [COORD_WIDTH-1:0]   w_in_x_adv;
    logic [COORD_WIDTH-1:0]   w_in_line_adv;
    logic [COORD_WIDTH-1:0]   w_out_x_adv;
    logic [COORD_WIDTH-1:0]   w_out_line_adv;
    logic                     w_sof;
    logic                     w_set_sof;
    logic                     w_set_eol;
    logic                     w_abort_nx;
    logic                     w_done_nx;
    logic                     w_in_allow_nx;
    logic                     w_out_allow_nx;

    // Saturating line increment: line counts stop at HEIGHT.
    function automatic logic [COORD_WIDTH-1:0] f_line_inc(input logic [COORD_WIDTH-1:0] i_l);
        return (i_l < LP_HEIGHT) ? (i_l + COORD_WIDTH'(1)) : i_l;
    endfunction

    // Output window: line out_line may be produced once the source line
    // out_line+LOOKAHEAD (clamped to the last line) is fully buffered.
    function automatic logic f_out_window(input logic [COORD_WIDTH-1:0] i_l,
                                          input logic [COORD_WIDTH-1:0] o_l);
        logic [COORD_WIDTH:0] v_need;
        v_need = {1'b0, o_l} + LP_LOOK;
        v_need = (v_need > LP_HEIGHT_M1) ? LP_HEIGHT_M1 : v_need;
        return (o_l < LP_HEIGHT) && ({1'b0, i_l} > v_need);
    endfunction

    // Input window: a free line slot exists and the frame is not fully read.
    // If the engine ever ran ahead of the input the difference is treated as
    // zero rather than letting the subtraction wrap.
    function automatic logic f_in_window(input logic [COORD_WIDTH-1:0] i_l,
                                         input logic [COORD_WIDTH-1:0] o_l);
        logic [COORD_WIDTH-1:0] v_diff;
        v_diff = i_l - o_l;
        return (i_l < LP_HEIGHT) && ((i_l <= o_l) || ({1'b0, v_diff} < LP_BUF));
    endfunction

    // Column/line position each side would reach if it accepted a beat now
    always_comb begin
        w_in_x_adv     = '0;
        w_in_line_adv  = r_in_line;
        w_out_x_adv    = '0;
        w_out_line_adv = r_out_line;
        if (r_in_x == LP_X_LAST) begin
            w_in_x_adv    = '0;
            w_in_line_adv = f_line_inc(r_in_line);
        end else begin
            w_in_x_adv    = r_in_x + COORD_WIDTH'(1);
            w_in_line_adv = r_in_line;
        end
        if (r_out_x == LP_X_LAST) begin
            w_out_x_adv    = '0;
            w_out_line_adv = f_line_inc(r_out_line);
        end else begin
            w_out_x_adv    = r_out_x + COORD_WIDTH'(1);
            w_out_line_adv = r_out_line;
        end
    end

    // Frame FSM next state, counter updates, framing checks and pulses
    always_comb begin
        w_state_nx    = r_state;
        w_in_x_nx     = r_in_x;
        w_in_line_nx  = r_in_line;
        w_out_x_nx    = r_out_x;
        w_out_line_nx = r_out_line;
        w_sof         = 1'b0;
        w_set_sof     = 1'b0;
        w_set_eol     = 1'b0;
        w_abort_nx    = 1'b0;
        w_done_nx     = 1'b0;
        case (r_state)
            ST_IDLE, ST_RESYNC: begin
                // Only an SOF beat starts a frame; everything else is dropped.
                if (in_beat && in_user) begin
                    w_sof         = 1'b1;
                    w_state_nx    = ST_RUN;
                    w_in_x_nx     = COORD_WIDTH'(1);
                    w_in_line_nx  = '0;
                    w_out_x_nx    = '0;
                    w_out_line_nx = '0;
                end else begin
                    w_state_nx    = r_state;
                    w_in_x_nx     = r_in_x;
                    w_in_line_nx  = r_in_line;
                end
            end
            ST_RUN: begin
                w_set_sof = in_beat && in_user;
                w_set_eol = in_beat && (in_last != (r_in_x == LP_X_LAST));
                if (w_set_sof || w_set_eol) begin
                    // Malformed frame: flush the engine and wait for a new SOF.
                    w_abort_nx    = 1'b1;
                    w_state_nx    = ST_RESYNC;
                    w_in_x_nx     = '0;
                    w_in_line_nx  = '0;
                    w_out_x_nx    = '0;
                    w_out_line_nx = '0;
                end else begin
                    if (in_beat) begin
                        w_in_x_nx    = w_in_x_adv;
                        w_in_line_nx = w_in_line_adv;
                    end else begin
                        w_in_x_nx    = r_in_x;
                        w_in_line_nx = r_in_line;
                    end
                    if (out_beat) begin
                        w_out_x_nx    = w_out_x_adv;
                        w_out_line_nx = w_out_line_adv;
                    end else begin
                        w_out_x_nx    = r_out_x;
                        w_out_line_nx = r_out_line;
                    end
                    if (w_in_line_nx == LP_HEIGHT) begin
                        w_state_nx = ST_DRAIN;
                    end else begin
                        w_state_nx = ST_RUN;
                    end
                end
            end
            ST_DRAIN: begin
                // Input side is closed; late input beats are ignored.
                if (out_beat) begin
                    w_out_x_nx    = w_out_x_adv;
                    w_out_line_nx = w_out_line_adv;
                end else begin
                    w_out_x_nx    = r_out_x;
                    w_out_line_nx = r_out_line;
                end
                if (w_out_line_nx == LP_HEIGHT) begin
                    w_done_nx     = 1'b1;
                    w_state_nx    = ST_IDLE;
                    w_in_x_nx     = '0;
                    w_in_line_nx  = '0;
                    w_out_x_nx    = '0;
                    w_out_line_nx = '0;
                end else begin
                    w_state_nx    = ST_DRAIN;
                end
            end
            default: begin
                w_state_nx    = ST_IDLE;
                w_in_x_nx     = '0;
                w_in_line_nx  = '0;
                w_out_x_nx    = '0;
                w_out_line_nx = '0;
            end
        endcase
    end

    // Window enables decoded from the next state so they register cleanly
    always_comb begin
        w_in_allow_nx  = 1'b0;
        w_out_allow_nx = 1'b0;
        case (w_state_nx)
            ST_IDLE, ST_RESYNC: begin
                w_in_allow_nx  = 1'b1;
                w_out_allow_nx = 1'b0;
            end
            ST_RUN: begin
                w_in_allow_nx  = f_in_window(w_in_line_nx, w_out_line_nx);
                w_out_allow_nx = f_out_window(w_in_line_nx, w_out_line_nx);
            end
            ST_DRAIN: begin
                w_in_allow_nx  = 1'b0;
                w_out_allow_nx = f_out_window(w_in_line_nx, w_out_line_nx);
            end
            default: begin
                w_in_allow_nx  = 1'b0;
                w_out_allow_nx = 1'b0;
            end
        endcase
    end

    // FSM state, beat counters, window enables and one-cycle pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_in_x       <= '0;
            r_in_line    <= '0;
            r_out_x      <= '0;
            r_out_line   <= '0;
            r_in_allow   <= 1'b0;
            r_out_allow  <= 1'b0;
            r_out_abort  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_in_x       <= w_in_x_nx;
            r_in_line    <= w_in_line_nx;
            r_out_x      <= w_out_x_nx;
            r_out_line   <= w_out_line_nx;
            r_in_allow   <= w_in_allow_nx;
            r_out_allow  <= w_out_allow_nx;
            r_out_abort  <= w_abort_nx;
            r_frame_done <= w_done_nx;
        end
    end

    // Sticky framing errors; a new error event beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_sof <= 1'b0;
            r_err_eol <= 1'b0;
        end else begin
            r_err_sof <= (r_err_sof && !err_clear) || w_set_sof;
            r_err_eol <= (r_err_eol && !err_clear) || w_set_eol;
        end
    end

    // Coefficient shadowing: pending value is applied only at an SOF, and an
    // update landing on the SOF cycle is kept for the following frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_k1       <= '0;
            r_pend_en       <= 1'b0;
            r_pend_vld      <= 1'b0;
            r_active_k1     <= '0;
            r_active_bypass <= 1'b1;
        end else begin
            if (w_sof && r_pend_vld) begin
                r_active_k1     <= r_pend_k1;
                r_active_bypass <= !r_pend_en;
            end else begin
                r_active_k1     <= r_active_k1;
                r_active_bypass <= r_active_bypass;
            end
            if (cfg_update) begin
                r_pend_k1  <= cfg_k1;
                r_pend_en  <= cfg_enable;
                r_pend_vld <= 1'b1;
            end else if (w_sof) begin
                r_pend_vld <= 1'b0;
            end else begin
                r_pend_vld <= r_pend_vld;
            end
        end
    end

    assign active_k1     = r_active_k1;
    assign active_bypass = r_active_bypass;
    assign in_allow      = r_in_allow;
    assign out_allow     = r_out_allow;
    assign out_abort     = r_out_abort;
    assign in_line       = r_in_line;
    assign out_line      = r_out_line;
    assign frame_done    = r_frame_done;
    assign err_sof       = r_err_sof;
    assign err_eol       = r_err_eol;
    assign state         = r_state;

endmodule

// File: tb/tb_distortion_frame_ctrl.sv
// Directed bench for distortion_frame_ctrl with an 8x6 frame, 4-line buffer
// and lookahead 2. Expected values are worked out by hand from the frame
// geometry; inputs are driven and outputs sampled 1 time unit after posedge.

module tb_distortion_frame_ctrl;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int BL = 4;
    localparam int LA = 2;
    localparam int CW = 16;
    localparam int KW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [KW-1:0] cfg_k1;
    logic          cfg_enable;
    logic          cfg_update;
    logic [KW-1:0] active_k1;
    logic          active_bypass;
    logic          in_beat;
    logic          in_last;
    logic          in_user;
    logic          in_allow;
    logic          out_beat;
    logic          out_allow;
    logic          out_abort;
    logic [CW-1:0] in_line;
    logic [CW-1:0] out_line;
    logic          frame_done;
    logic          err_sof;
    logic          err_eol;
    logic          err_clear;
    logic [1:0]    state;

    int n_chk = 0;
    int n_err = 0;
    int n_in;
    int n_out;
    int oa_first;
    int ia_fall;
    int drain_line;
    int done_cnt;
    int done_at;

    always #5 clk = ~clk;

    distortion_frame_ctrl #(
        .WIDTH(W), .HEIGHT(H), .BUFFER_LINES(BL), .LOOKAHEAD(LA),
        .COORD_WIDTH(CW), .K_WIDTH(KW)
    ) u_dut (
        .clk(clk), .rst(rst),
        .cfg_k1(cfg_k1), .cfg_enable(cfg_enable), .cfg_update(cfg_update),
        .active_k1(active_k1), .active_bypass(active_bypass),
        .in_beat(in_beat), .in_last(in_last), .in_user(in_user), .in_allow(in_allow),
        .out_beat(out_beat), .out_allow(out_allow), .out_abort(out_abort),
        .in_line(in_line), .out_line(out_line), .frame_done(frame_done),
        .err_sof(err_sof), .err_eol(err_eol), .err_clear(err_clear),
        .state(state)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock with the given inputs, then return all pulses to idle.
    task automatic step(input logic ib, input logic il, input logic iu, input logic ob,
                        input logic cu, input logic [KW-1:0] k, input logic en, input logic ec);
        in_beat    = ib;
        in_last    = il;
        in_user    = iu;
        out_beat   = ob;
        cfg_update = cu;
        cfg_k1     = k;
        cfg_enable = en;
        err_clear  = ec;
        @(posedge clk);
        #1;
        in_beat    = 1'b0;
        in_last    = 1'b0;
        in_user    = 1'b0;
        out_beat   = 1'b0;
        cfg_update = 1'b0;
        err_clear  = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic clr_rec();
        oa_first   = -1;
        ia_fall    = -1;
        drain_line = -1;
        done_cnt   = 0;
        done_at    = -1;
    endtask

    // Well-behaved source/sink: issue beats only inside the windows, tlast on
    // column W-1, tuser on the first beat of the frame; record key events.
    task automatic drive(input int in_total, input bit out_en, input int cycles);
        logic ib;
        logic ob;
        for (int c = 0; c < cycles; c++) begin
            ib = in_allow && (n_in < in_total);
            ob = out_en && out_allow;
            step(ib, ib && ((n_in % W) == (W - 1)), ib && (n_in == 0), ob,
                 1'b0, 16'h0000, 1'b0, 1'b0);
            if (ib) n_in++;
            if (ob) n_out++;
            if (out_allow && oa_first < 0) oa_first = n_in;
            if (!in_allow && state == 2'd1 && ia_fall < 0) ia_fall = n_in;
            if (state == 2'd2 && drain_line < 0) drain_line = int'(in_line);
            if (frame_done) begin
                done_cnt++;
                done_at = n_out;
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        cfg_k1     = 16'h0000;
        cfg_enable = 1'b0;
        cfg_update = 1'b0;
        in_beat    = 1'b0;
        in_last    = 1'b0;
        in_user    = 1'b0;
        out_beat   = 1'b0;
        err_clear  = 1'b0;
        n_in       = 0;
        n_out      = 0;
        clr_rec();

        // Reset state
        repeat (3) idle();
        check_val("rst_in_allow", 32'(in_allow), 32'd0);
        check_val("rst_state", 32'(state), 32'd0);
        check_val("rst_k1", 32'(active_k1), 32'h0);
        check_val("rst_bypass", 32'(active_bypass), 32'd1);
        check_val("rst_flags", 32'({out_allow, out_abort, frame_done, err_sof, err_eol}), 32'd0);
        check_val("rst_lines", {in_line, out_line}, 32'd0);
        rst = 1'b0;
        idle();
        check_val("rel_in_allow", 32'(in_allow), 32'd1);
        check_val("rel_state", 32'(state), 32'd0);

        // Pending config waits for the SOF
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b1, 1'b0);
        check_val("pend_not_applied", 32'(active_k1), 32'h0);

        // Frame 1: free running
        clr_rec();
        n_in  = 0;
        n_out = 0;
        drive(48, 1'b1, 30);
        check_val("f1_k1", 32'(active_k1), 32'h0100);
        check_val("f1_bypass", 32'(active_bypass), 32'd0);
        check_val("f1_out_allow_rise", 32'(oa_first), 32'd24);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0300, 1'b1, 1'b0);
        check_val("mid_cfg_held", 32'(active_k1), 32'h0100);
        drive(48, 1'b1, 100);
        check_val("f1_drain_in_line", 32'(drain_line), 32'd6);
        check_val("f1_done_count", 32'(done_cnt), 32'd1);
        check_val("f1_done_at_out", 32'(done_at), 32'd48);
        check_val("f1_end_state", 32'(state), 32'd0);
        check_val("f1_end_lines", {in_line, out_line}, 32'd0);

        // Frame 2: backpressure
        clr_rec();
        n_in  = 0;
        n_out = 0;
        drive(48, 1'b0, 40);
        check_val("f2_k1", 32'(active_k1), 32'h0300);
        check_val("bp_in_allow_fall", 32'(ia_fall), 32'd32);
        check_val("bp_in_line", 32'(in_line), 32'd4);
        check_val("bp_in_allow_held", 32'(in_allow), 32'd0);
        check_val("bp_out_allow", 32'(out_allow), 32'd1);
        drive(48, 1'b1, 7);
        check_val("bp_after7_in_allow", 32'(in_allow), 32'd0);
        check_val("bp_after7_out_line", 32'(out_line), 32'd0);
        drive(48, 1'b1, 1);
        check_val("bp_after8_in_allow", 32'(in_allow), 32'd1);
        check_val("bp_after8_out_line", 32'(out_line), 32'd1);
        drive(48, 1'b1, 150);
        check_val("f2_done_count", 32'(done_cnt), 32'd1);
        check_val("f2_end_state", 32'(state), 32'd0);

        // Frame 3: update coincident with SOF, then early tlast
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0500, 1'b1, 1'b0);
        n_in = 1;
        check_val("sof_cfg_state", 32'(state), 32'd1);
        check_val("sof_cfg_k1_old", 32'(active_k1), 32'h0300);
        drive(12, 1'b0, 20);
        check_val("eol_pre_in_line", 32'(in_line), 32'd1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check_val("eol_err", 32'(err_eol), 32'd1);
        check_val("eol_abort", 32'(out_abort), 32'd1);
        check_val("eol_state", 32'(state), 32'd3);
        check_val("eol_allows", 32'({in_allow, out_allow}), 32'd2);
        check_val("eol_in_line", 32'(in_line), 32'd0);
        check_val("eol_no_sof_err", 32'(err_sof), 32'd0);
        idle();
        check_val("eol_abort_one_cycle", 32'(out_abort), 32'd0);
        check_val("eol_sticky", 32'(err_eol), 32'd1);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check_val("resync_discard", 32'(state), 32'd3);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        n_in = 1;
        check_val("resync_restart", 32'(state), 32'd1);
        check_val("resync_in_line", 32'(in_line), 32'd0);
        check_val("resync_k1_new", 32'(active_k1), 32'h0500);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        check_val("eol_cleared", 32'(err_eol), 32'd0);

        // Stray SOF at in_line 2
        drive(17, 1'b0, 30);
        check_val("sof_pre_in_line", 32'(in_line), 32'd2);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check_val("sof_err", 32'(err_sof), 32'd1);
        check_val("sof_abort", 32'(out_abort), 32'd1);
        check_val("sof_state", 32'(state), 32'd3);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        check_val("sof_cleared", 32'(err_sof), 32'd0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        check_val("sof_set_wins", 32'(err_sof), 32'd1);

        // Reset mid-frame at in_line 3, with a config still pending
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        n_in = 1;
        drive(25, 1'b0, 40);
        check_val("mr_pre_in_line", 32'(in_line), 32'd3);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0700, 1'b0, 1'b0);
        rst = 1'b1;
        idle();
        check_val("mr_state", 32'(state), 32'd0);
        check_val("mr_lines", {in_line, out_line}, 32'd0);
        check_val("mr_in_allow", 32'(in_allow), 32'd0);
        check_val("mr_k1", 32'(active_k1), 32'h0);
        check_val("mr_bypass", 32'(active_bypass), 32'd1);
        check_val("mr_flags", 32'({out_allow, out_abort, frame_done, err_sof, err_eol}), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, ((i % W) == (W - 1)), 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
            if (i == 0) check_val("mr_rel_in_allow", 32'(in_allow), 32'd1);
        end
        check_val("mr_drop_state", 32'(state), 32'd0);
        check_val("mr_drop_in_line", 32'(in_line), 32'd0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        check_val("mr_sof_state", 32'(state), 32'd1);
        check_val("mr_pending_gone_k1", 32'(active_k1), 32'h0);
        check_val("mr_pending_gone_bypass", 32'(active_bypass), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/distortion_frame_ctrl.md
# distortion_frame_ctrl

Frame and line-window sequencer for the barrel distortion correction datapath. It observes accepted input and output AXI4-Stream beats and gates upstream `tready` and remap-engine issue, so that the engine only emits output line y once source lines up to y+LOOKAHEAD are buffered, and input never overwrites a line still needed. It also validates frame framing (tuser/tlast), recovers from malformed frames, and applies the distortion coefficient atomically at frame boundaries through shadow registers.

## Interface
- `WIDTH`, 1920, pixels per line
- `HEIGHT`, 1080, lines per frame
- `BUFFER_LINES`, 4, line-buffer depth in lines
- `LOOKAHEAD`, 2, source lines needed below the output line; constraint 0 ≤ LOOKAHEAD ≤ BUFFER_LINES-1
- `COORD_WIDTH`, 16, counter width
- `K_WIDTH`, 16, coefficient width (signed 4.12)

Ports:
- `clk` in 1, sole clock
- `rst` in 1, synchronous, active-high reset
- `cfg_k1` in K_WIDTH, requested K1
- `cfg_enable` in 1, requested correction enable
- `cfg_update` in 1, one-cycle pulse: capture `cfg_k1`/`cfg_enable` as pending
- `active_k1` out K_WIDTH, K1 in force for the current frame
- `active_bypass` out 1, 1 = pass-through (correction disabled)
- `in_beat` in 1, input handshake (s tvalid&tready) occurred
- `in_last` in 1, s_axis_tlast of that beat
- `in_user` in 1, s_axis_tuser of that beat
- `in_allow` out 1, upstream tready enable
- `out_beat` in 1, output handshake (m tvalid&tready) occurred
- `out_allow` out 1, remap engine may issue pixels
- `out_abort` out 1, one-cycle pulse: flush remap pipeline
- `in_line` out COORD_WIDTH, completed input lines this frame
- `out_line` out COORD_WIDTH, completed output lines this frame
- `frame_done` out 1, one-cycle pulse when the last output line completes
- `err_sof` out 1, sticky: tuser mid-frame
- `err_eol` out 1, sticky: tlast early, or missing at column WIDTH-1
- `err_clear` in 1, clears both sticky errors
- `state` out 2, debug: 0 IDLE, 1 RUN, 2 DRAIN, 3 RESYNC

## Operation
- **Counters.**
  - `in_x` and `out_x` count beats within a line, range 0..WIDTH-1.
  - A beat at x = WIDTH-1 wraps x to 0 and increments the line count.
  - Line counts saturate at HEIGHT.
- **IDLE.**
  - `in_allow`=1, `out_allow`=0.
  - Beats without `in_user` are dropped silently, with no error.
  - A beat with `in_user` is the SOF:
    - counters cleared, then that beat is counted (`in_x`=1);
    - the pending config, if any, is copied to `active_k1` and `active_bypass`=!enable;
    - the pending flag is cleared;
    - transition to RUN.
- **RUN.**
  - `in_allow` = (in_line − out_line < BUFFER_LINES) && (in_line < HEIGHT).
  - `out_allow` = (out_line < HEIGHT) && (in_line > min(out_line+LOOKAHEAD, HEIGHT−1)).
  - When in_line reaches HEIGHT, transition to DRAIN.
- **DRAIN.**
  - `in_allow`=0; `out_allow` follows the same equation as RUN.
  - When out_line reaches HEIGHT: `frame_done` pulses, counters clear, transition to IDLE.
- **Framing errors.** Each of the following sets the named sticky error, pulses `out_abort`, clears all counters and transitions to RESYNC:
  - `in_last` at in_x ≠ WIDTH−1 → `err_eol`;
  - no `in_last` at in_x = WIDTH−1 → `err_eol`;
  - `in_user` in RUN → `err_sof`.
- **RESYNC.**
  - `in_allow`=1, `out_allow`=0.
  - Beats are discarded until an `in_user` beat, which is handled exactly as an SOF in IDLE.
- **Out-of-window beats.** `out_beat` while `out_allow`=0 is still counted; the upstream engine must not do this.
- **Config capture.**
  - `cfg_update` overwrites the pending value (last write wins).
  - If `cfg_update` and the SOF occur in the same cycle, the previously pending value is applied. The new value stays pending for the next frame.
- **Error clear.** If `err_clear` and an error event occur in the same cycle, the error is set (set wins).

## Timing
- All state, counters and flags are registered.
- `in_allow`, `out_allow` and `state` decode registered state only, with no combinational input→output path.
- A beat that completes a line changes `in_allow`/`out_allow` in the next cycle. At most one extra beat can reach the boundary, and the window has no slack requirement beyond that.
- `out_abort` and `frame_done` are high for exactly the cycle after the triggering beat.
- Reset values (while `rst` is high and in the first cycle after release):
  - `state`=IDLE;
  - all counters 0;
  - `active_k1`=0, `active_bypass`=1, pending cleared;
  - `in_allow`=0 while `rst` is high, 1 after release;
  - `out_allow`, `out_abort`, `frame_done`, `err_sof`, `err_eol` = 0.
- Reset mid-frame abandons the frame. Subsequent beats without `in_user` are dropped.

## Test plan
Parameters for all scenarios: WIDTH=8, HEIGHT=6, BUFFER_LINES=4, LOOKAHEAD=2.
- **Free-running frame:**
  - SOF followed by 48 beats, with out_beat issued every cycle `out_allow`=1;
  - `out_allow` rises the cycle after in_beat #24;
  - `in_line` reaches 6 → DRAIN;
  - `frame_done` pulses once, the cycle after out_beat #48 → IDLE.
- **Backpressure:**
  - no out_beat is issued;
  - `in_allow` falls the cycle after in_beat #32 and stays 0;
  - after 8 out_beats it returns to 1.
- **Early tlast:** `in_last` on the 5th beat of line 1 → `err_eol`=1, `out_abort` pulse, state=3, `in_allow`=1, `out_allow`=0. The next `in_user` beat restarts the frame with in_line=0.
- **Config shadowing:**
  - `cfg_update` with k1=0x0300 mid-frame → `active_k1` unchanged until the next SOF, then 0x0300;
  - update coincident with SOF → applied one frame later.
- **Reset mid-frame:**
  - `rst` asserted at in_line=3 → all outputs take their reset values the next cycle;
  - the following 10 non-SOF beats are dropped;
  - state stays IDLE.
- **Stray SOF:** `in_user` at in_line=2 → `err_sof`=1. `err_clear` then drops it to 0 unless an error event occurs in the same cycle.
